// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - timing constants shared by the switch debounce bank
package debounce_pkg;

    localparam int CLK_HZ        = 25_000_000;
    localparam int DEBOUNCE_MS   = 10;
    localparam int DEFAULT_LIMIT = CLK_HZ / 1000 * DEBOUNCE_MS;

endpackage

// File: rtl/switch_debounce_bank_if.sv
// rtl/switch_debounce_bank_if.sv - raw switch inputs and filtered switch outputs
interface switch_debounce_bank_if #(
    parameter int NUM_SW = 4
);

    logic [NUM_SW-1:0] sw;
    logic [NUM_SW-1:0] debounced;
    logic [NUM_SW-1:0] rise;
    logic [NUM_SW-1:0] fall;
    logic [NUM_SW-1:0] toggle;

    modport master (
        output sw,
        input  debounced,
        input  rise,
        input  fall,
        input  toggle
    );

    modport slave (
        input  sw,
        output debounced,
        output rise,
        output fall,
        output toggle
    );

endinterface

// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - one switch channel: synchroniser, stability counter, edge and toggle flops
module debounce_filter #(
    parameter int DEBOUNCE_LIMIT = 4
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Debounced,
    output logic o_Rise,
    output logic o_Fall,
    output logic o_Toggle
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stb_q, stb_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             tog_q, tog_d;

    always_comb begin
        cnt_d  = '0;
        stb_d  = stb_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        tog_d  = tog_q;
        // A mismatch must persist for DEBOUNCE_LIMIT consecutive cycles to be accepted.
        if (sync2_q != stb_q) begin
            if (cnt_q == CNT_LAST) begin
                stb_d  = sync2_q;
                rise_d = sync2_q;
                fall_d = ~sync2_q;
                if (sync2_q) begin
                    tog_d = ~tog_q;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            tog_q   <= 1'b0;
        end else begin
            sync1_q <= i_Switch;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            tog_q   <= tog_d;
        end
    end

    assign o_Debounced = stb_q;
    assign o_Rise      = rise_q;
    assign o_Fall      = fall_q;
    assign o_Toggle    = tog_q;

endmodule

// File: rtl/switch_debounce_bank.sv
// rtl/switch_debounce_bank.sv - bank of independent debounce channels for the board push-switches
module switch_debounce_bank
    import debounce_pkg::*;
#(
    parameter int NUM_SW         = 4,
    parameter int DEBOUNCE_LIMIT = DEFAULT_LIMIT
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    switch_debounce_bank_if.slave sw_if
);

    for (genvar n = 0; n < NUM_SW; n++) begin : g_ch
        debounce_filter #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
        ) u_filter (
            .i_Clk      (i_Clk),
            .i_Rst      (i_Rst),
            .i_Switch   (sw_if.sw[n]),
            .o_Debounced(sw_if.debounced[n]),
            .o_Rise     (sw_if.rise[n]),
            .o_Fall     (sw_if.fall[n]),
            .o_Toggle   (sw_if.toggle[n])
        );
    end

endmodule

// File: tb/tb_switch_debounce_bank.sv
// tb/tb_switch_debounce_bank.sv - directed self-checking bench for switch_debounce_bank
module tb_switch_debounce_bank;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    switch_debounce_bank_if #(.NUM_SW(4)) bus4 ();
    switch_debounce_bank_if #(.NUM_SW(4)) bus1 ();

    switch_debounce_bank #(.NUM_SW(4), .DEBOUNCE_LIMIT(4)) dut4 (
        .i_Clk(clk), .i_Rst(rst), .sw_if(bus4.slave)
    );

    switch_debounce_bank #(.NUM_SW(4), .DEBOUNCE_LIMIT(1)) dut1 (
        .i_Clk(clk), .i_Rst(rst), .sw_if(bus1.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus4.sw = 4'hF;
        bus1.sw = 4'h0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_tests++;
            if ({bus4.debounced, bus4.rise, bus4.fall, bus4.toggle} !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=0000", i,
                         {bus4.debounced, bus4.rise, bus4.fall, bus4.toggle});
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_tests++;
            if (bus4.rise !== ((i == 6) ? 4'hF : 4'h0)) begin
                n_fail++;
                $display("FAIL reset_rise cyc=%0d got=%h exp=%h", i, bus4.rise, (i == 6) ? 4'hF : 4'h0);
            end
            n_tests++;
            if (bus4.debounced !== ((i >= 6) ? 4'hF : 4'h0)) begin
                n_fail++;
                $display("FAIL reset_level cyc=%0d got=%h", i, bus4.debounced);
            end
            n_tests++;
            if (bus4.toggle !== ((i >= 6) ? 4'hF : 4'h0)) begin
                n_fail++;
                $display("FAIL reset_toggle cyc=%0d got=%h", i, bus4.toggle);
            end
        end
        bus4.sw = 4'h0;
        settle(10);
        n_tests++;
        if (bus4.debounced !== 4'h0 || bus4.toggle !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_release_all got deb=%h tog=%h exp deb=0 tog=f", bus4.debounced, bus4.toggle);
        end
    endtask

    task automatic test_clean_press();
        bus4.sw[0] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_tests++;
            if (bus4.rise[0] !== (i == 6) || bus4.fall[0] !== 1'b0 || bus4.toggle[0] !== (i < 6)) begin
                n_fail++;
                $display("FAIL press_ch0 cyc=%0d got r=%b f=%b t=%b", i, bus4.rise[0], bus4.fall[0], bus4.toggle[0]);
            end
        end
        bus4.sw[0] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_tests++;
            if (bus4.fall[0] !== (i == 6) || bus4.rise[0] !== 1'b0 || bus4.toggle[0] !== 1'b0
                || bus4.debounced[0] !== (i < 6)) begin
                n_fail++;
                $display("FAIL release_ch0 cyc=%0d got r=%b f=%b t=%b d=%b", i,
                         bus4.rise[0], bus4.fall[0], bus4.toggle[0], bus4.debounced[0]);
            end
        end
    endtask

    task automatic test_bounce();
        logic v;
        v = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus4.sw[1] = v;
            v = ~v;
            tick();
            n_tests++;
            if (bus4.rise[1] !== 1'b0 || bus4.debounced[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_quiet cyc=%0d got r=%b d=%b exp 0", i, bus4.rise[1], bus4.debounced[1]);
            end
        end
        bus4.sw[1] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_tests++;
            if (bus4.rise[1] !== (i == 6) || bus4.debounced[1] !== (i >= 6)) begin
                n_fail++;
                $display("FAIL bounce_settle cyc=%0d got r=%b d=%b", i, bus4.rise[1], bus4.debounced[1]);
            end
        end
        bus4.sw[1] = 1'b0;
        settle(3);
        bus4.sw[1] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_tests++;
            if (bus4.fall[1] !== 1'b0 || bus4.debounced[1] !== 1'b1 || bus4.toggle[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL short_run cyc=%0d got f=%b d=%b t=%b exp 0 1 0", i,
                         bus4.fall[1], bus4.debounced[1], bus4.toggle[1]);
            end
        end
    endtask

    task automatic test_simultaneous();
        bus4.sw[3] = 1'b1;
        settle(10);
        bus4.sw[2] = 1'b1;
        bus4.sw[3] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_tests++;
            if (bus4.rise !== ((i == 6) ? 4'b0100 : 4'b0000) || bus4.fall !== ((i == 6) ? 4'b1000 : 4'b0000)) begin
                n_fail++;
                $display("FAIL simul_pulse cyc=%0d got r=%b f=%b", i, bus4.rise, bus4.fall);
            end
            n_tests++;
            if (bus4.debounced[1:0] !== 2'b10 || bus4.toggle[2] !== (i < 6)) begin
                n_fail++;
                $display("FAIL simul_other cyc=%0d got d10=%b t2=%b", i, bus4.debounced[1:0], bus4.toggle[2]);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        bus4.sw[0] = 1'b1;
        settle(4);
        rst = 1'b1;
        tick();
        n_tests++;
        if ({bus4.debounced, bus4.rise, bus4.fall, bus4.toggle} !== 16'h0) begin
            n_fail++;
            $display("FAIL midrst_clear got=%h exp=0000", {bus4.debounced, bus4.rise, bus4.fall, bus4.toggle});
        end
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_tests++;
            if (bus4.rise !== ((i == 6) ? 4'b0111 : 4'b0000) || bus4.debounced !== ((i >= 6) ? 4'b0111 : 4'b0000)
                || bus4.toggle !== ((i >= 6) ? 4'b0111 : 4'b0000)) begin
                n_fail++;
                $display("FAIL midrst_restart cyc=%0d got r=%b d=%b t=%b", i, bus4.rise, bus4.debounced, bus4.toggle);
            end
        end
    endtask

    task automatic test_toggle_and_limit1();
        bus4.sw[3] = 1'b1;
        settle(10);
        n_tests++;
        if (bus4.toggle[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_press1 got=%b exp=1", bus4.toggle[3]);
        end
        bus4.sw[3] = 1'b0;
        settle(10);
        bus4.sw[3] = 1'b1;
        settle(10);
        n_tests++;
        if (bus4.toggle[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_press2 got=%b exp=0", bus4.toggle[3]);
        end
        bus1.sw[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_tests++;
            if (bus1.rise[0] !== (i == 3) || bus1.debounced[0] !== (i >= 3)) begin
                n_fail++;
                $display("FAIL lim1_rise cyc=%0d got r=%b d=%b", i, bus1.rise[0], bus1.debounced[0]);
            end
        end
        bus1.sw[0] = 1'b0;
        tick();
        bus1.sw[0] = 1'b1;
        for (int i = 2; i <= 6; i++) begin
            tick();
            n_tests++;
            if (bus1.fall[0] !== (i == 3) || bus1.rise[0] !== (i == 4)) begin
                n_fail++;
                $display("FAIL lim1_glitch cyc=%0d got r=%b f=%b", i, bus1.rise[0], bus1.fall[0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus4.sw = 4'h0;
        bus1.sw = 4'h0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_toggle_and_limit1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
